// File: rtl/lte_up_dfe_iq_pair.sv
// rtl/lte_up_dfe_iq_pair.sv - re-pairs transposed I/Q slot words into parallel beats with alignment and fill checks
module lte_up_dfe_iq_pair #(
    parameter int NUM_ANT    = 4,
    parameter bit CHECK_FILL = 1'b1
) (
    input  logic        sys_clk_245p76,
    input  logic        sys_rst_245p76,
    input  logic [1:0]  i_mod_sel,
    input  logic        i_fram,
    input  logic        i_xant,
    input  logic [31:0] i_data,
    input  logic        i_err_clr,
    output logic        o_vld,
    output logic [31:0] o_data_i,
    output logic [31:0] o_data_q,
    output logic [1:0]  o_ant,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_fram,
    output logic        o_align_err,
    output logic [7:0]  o_align_cnt,
    output logic [7:0]  o_fill_cnt
);

    localparam logic [1:0] ANT_MAX = 2'(NUM_ANT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [4:0]  phase;
    logic [4:0]  len_m1;
    logic [1:0]  ant;
    logic        fram_slot;
    logic [31:0] ibuf [8];

    // i_fram overrides the running counters in its own cycle, so all decisions use these views
    logic        active;
    logic [4:0]  cur_phase;
    logic [4:0]  cur_len_m1;
    logic [1:0]  cur_ant;
    logic [1:0]  ant_inc;
    logic        cur_fram_slot;
    logic        misalign;
    logic        slot_end;
    logic        fill_hit;
    logic        store_i;
    logic        beat;
    logic [2:0]  k;

    // Effective phase/antenna/length for this cycle, plus the per-cycle event decode
    always_comb begin
        active        = i_fram || (state == RUN);
        cur_phase     = i_fram ? 5'd0 : phase;
        cur_len_m1    = i_fram ? (((i_mod_sel == 2'd1) || (i_mod_sel == 2'd2)) ? 5'd31 : 5'd15) : len_m1;
        cur_ant       = i_fram ? 2'd0 : ant;
        cur_fram_slot = i_fram || fram_slot;
        ant_inc       = (cur_ant == ANT_MAX) ? 2'd0 : cur_ant + 2'd1;
        misalign      = active && i_xant && !i_fram && (cur_phase != cur_len_m1);
        slot_end      = (cur_phase == cur_len_m1) || misalign;
        fill_hit      = active && CHECK_FILL && cur_phase[4] && (i_data != 32'd0);
        store_i       = active && (cur_phase[4:3] == 2'b00);
        beat          = active && (cur_phase[4:3] == 2'b01);
        k             = cur_phase[2:0];
    end

    // Slot sequencer: phase/antenna tracking, resync on i_fram, early wrap on misaligned i_xant
    always_ff @(posedge sys_clk_245p76) begin
        if (sys_rst_245p76) begin
            state     <= IDLE;
            phase     <= 5'd0;
            len_m1    <= 5'd31;
            ant       <= 2'd0;
            fram_slot <= 1'b0;
        end else if (active) begin
            state  <= RUN;
            len_m1 <= cur_len_m1;
            if (slot_end) begin
                phase     <= 5'd0;
                ant       <= ant_inc;
                fram_slot <= 1'b0;
            end else begin
                phase     <= cur_phase + 5'd1;
                ant       <= cur_ant;
                fram_slot <= cur_fram_slot;
            end
        end
    end

    // I words are simply overwritten each slot, so an abandoned pairing needs no explicit flush
    always_ff @(posedge sys_clk_245p76) begin
        if (store_i) begin
            ibuf[k] <= i_data;
        end
    end

    // Paired beat output, one cycle after the matching Q word; data and antenna hold between beats
    always_ff @(posedge sys_clk_245p76) begin
        if (sys_rst_245p76) begin
            o_vld    <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            o_fram   <= 1'b0;
            o_ant    <= 2'd0;
            o_data_i <= 32'd0;
            o_data_q <= 32'd0;
        end else begin
            o_vld  <= beat;
            o_sop  <= beat && (k == 3'd0);
            o_eop  <= beat && (k == 3'd7);
            o_fram <= beat && (k == 3'd0) && (cur_ant == 2'd0) && cur_fram_slot;
            if (beat) begin
                o_ant    <= cur_ant;
                o_data_i <= ibuf[k];
                o_data_q <= i_data;
            end
        end
    end

    // Error counters and sticky flag; a clear in the same cycle as an increment wins
    always_ff @(posedge sys_clk_245p76) begin
        if (sys_rst_245p76 || i_err_clr) begin
            o_align_err <= 1'b0;
            o_align_cnt <= 8'd0;
            o_fill_cnt  <= 8'd0;
        end else begin
            if (misalign) begin
                o_align_err <= 1'b1;
                if (o_align_cnt != 8'hFF) begin
                    o_align_cnt <= o_align_cnt + 8'd1;
                end
            end
            if (fill_hit && (o_fill_cnt != 8'hFF)) begin
                o_fill_cnt <= o_fill_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lte_up_dfe_iq_pair.sv
// tb/tb_lte_up_dfe_iq_pair.sv - self-checking bench for lte_up_dfe_iq_pair
module tb_lte_up_dfe_iq_pair;

    localparam int NUM_ANT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  i_mod_sel = 2'd1;
    logic        i_fram = 1'b0;
    logic        i_xant = 1'b0;
    logic [31:0] i_data = 32'd0;
    logic        i_err_clr = 1'b0;
    logic        o_vld, o_sop, o_eop, o_fram, o_align_err;
    logic [31:0] o_data_i, o_data_q;
    logic [1:0]  o_ant;
    logic [7:0]  o_align_cnt, o_fill_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lte_up_dfe_iq_pair #(.NUM_ANT(NUM_ANT), .CHECK_FILL(1'b1)) dut (
        .sys_clk_245p76 (clk),
        .sys_rst_245p76 (rst),
        .i_mod_sel      (i_mod_sel),
        .i_fram         (i_fram),
        .i_xant         (i_xant),
        .i_data         (i_data),
        .i_err_clr      (i_err_clr),
        .o_vld          (o_vld),
        .o_data_i       (o_data_i),
        .o_data_q       (o_data_q),
        .o_ant          (o_ant),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .o_fram         (o_fram),
        .o_align_err    (o_align_err),
        .o_align_cnt    (o_align_cnt),
        .o_fill_cnt     (o_fill_cnt)
    );

    // Reference model: a slot is a list of len words, words 0-7 are I, 8-15 Q, rest fill
    bit          m_run = 0;
    int          m_phase = 0, m_ant = 0, m_len = 32;
    bit          m_from_fram = 0;
    logic [31:0] m_i [8];
    bit          e_vld, e_sop, e_eop, e_fram, e_err;
    logic [1:0]  e_ant;
    logic [31:0] e_di, e_dq;
    int          e_acnt, e_fcnt;

    function automatic void model_step();
        int p;
        bit mis;
        e_vld = 0; e_sop = 0; e_eop = 0; e_fram = 0;
        if (rst) begin
            m_run = 0; m_phase = 0; m_ant = 0; m_len = 32; m_from_fram = 0;
            e_ant = 0; e_di = 0; e_dq = 0; e_err = 0; e_acnt = 0; e_fcnt = 0;
            return;
        end
        if (i_fram) begin
            m_run = 1; m_phase = 0; m_ant = 0; m_from_fram = 1;
            m_len = (i_mod_sel == 1 || i_mod_sel == 2) ? 32 : 16;
        end
        if (m_run) begin
            p = m_phase;
            if (p < 8) m_i[p] = i_data;
            else if (p < 16) begin
                e_vld = 1;
                e_di = m_i[p - 8];
                e_dq = i_data;
                e_sop = (p == 8);
                e_eop = (p == 15);
                e_fram = (p == 8) && m_from_fram && (m_ant == 0);
                e_ant = 2'(m_ant);
            end else if (i_data != 0 && e_fcnt < 255) e_fcnt++;
            mis = i_xant && !i_fram && (p != m_len - 1);
            if (mis) begin
                e_err = 1;
                if (e_acnt < 255) e_acnt++;
            end
            if (mis || p == m_len - 1) begin
                m_phase = 0;
                m_ant = (m_ant + 1) % NUM_ANT;
                m_from_fram = 0;
            end else m_phase = p + 1;
        end
        if (i_err_clr) begin
            e_acnt = 0; e_fcnt = 0; e_err = 0;
        end
    endfunction

    int          sop_ants[$];
    int          fram_seen, eop_seen, vld_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive, advance the model, compare everything against it
    task automatic step(input logic fr, input logic xa, input logic [1:0] ms,
                        input logic [31:0] d, input logic clr, input logic rs);
        logic [86:0] act, exp;
        i_fram = fr; i_xant = xa; i_mod_sel = ms; i_data = d; i_err_clr = clr; rst = rs;
        model_step();
        @(posedge clk);
        #1;
        act = {o_vld, o_sop, o_eop, o_fram, o_ant, o_data_i, o_data_q, o_align_err, o_align_cnt, o_fill_cnt};
        exp = {e_vld, e_sop, e_eop, e_fram, e_ant, e_di, e_dq, e_err, 8'(e_acnt), 8'(e_fcnt)};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model t=%0t got %h expected %h", $time, act, exp);
        end
        if (o_vld) vld_seen++;
        if (o_vld && o_sop) sop_ants.push_back(int'(o_ant));
        if (o_fram) fram_seen++;
        if (o_eop) eop_seen++;
    endtask

    task automatic run_slot(input bit start, input int len, input int xat,
                            input logic [31:0] fill, input int nfill);
        logic [31:0] d;
        logic [1:0]  ms;
        ms = (len == 32) ? 2'd1 : 2'd3;
        for (int p = 0; p < len; p++) begin
            if (p < 8) d = 32'h100 + 32'(p);
            else if (p < 16) d = 32'h200 + 32'(p - 8);
            else d = (p - 16 < nfill) ? fill : 32'd0;
            step(start && p == 0, p == xat, ms, d, 1'b0, 1'b0);
            if (p == xat) break;
        end
    endtask

    task automatic clear_stats();
        sop_ants.delete();
        fram_seen = 0; eop_seen = 0; vld_seen = 0;
    endtask

    typedef struct {
        logic        rs, fr, xa;
        logic [31:0] d;
        logic        vld, sop, eop, fo;
        logic [1:0]  ant;
        logic [31:0] di, dq;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [74:0] act, exp;
        int p;

        // Table: reset, then one 20M slot with I=0x100+k, Q=0x200+k, then idle phase 0 of next slot
        tbl[0] = '{1, 0, 0, 32'h0, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0};
        tbl[1] = '{1, 0, 0, 32'hFFFF, 0, 0, 0, 0, 2'd0, 32'h0, 32'h0};
        for (int t = 2; t < 18; t++) begin
            p = t - 2;
            tbl[t].rs  = 0;
            tbl[t].fr  = (p == 0);
            tbl[t].xa  = (p == 15);
            tbl[t].d   = (p < 8) ? 32'h100 + 32'(p) : 32'h200 + 32'(p - 8);
            tbl[t].vld = (p >= 8);
            tbl[t].sop = (p == 8);
            tbl[t].eop = (p == 15);
            tbl[t].fo  = (p == 8);
            tbl[t].ant = 2'd0;
            tbl[t].di  = (p >= 8) ? 32'h100 + 32'(p - 8) : 32'h0;
            tbl[t].dq  = (p >= 8) ? 32'h200 + 32'(p - 8) : 32'h0;
        end
        tbl[18] = '{0, 0, 0, 32'h55, 0, 0, 0, 0, 2'd0, 32'h107, 32'h207};

        for (int t = 0; t < 19; t++) begin
            i_fram = tbl[t].fr; i_xant = tbl[t].xa; i_mod_sel = 2'd3;
            i_data = tbl[t].d; i_err_clr = 0; rst = tbl[t].rs;
            model_step();
            @(posedge clk);
            #1;
            act = {o_vld, o_sop, o_eop, o_fram, o_ant, o_data_i, o_data_q, o_align_err};
            exp = {tbl[t].vld, tbl[t].sop, tbl[t].eop, tbl[t].fo, tbl[t].ant, tbl[t].di, tbl[t].dq, 1'b0};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL table row %0d got %h expected %h", t, act, exp);
            end
        end

        // Basic 10M pairing over five slots
        step(0, 0, 1, 0, 1, 1);
        clear_stats();
        run_slot(1, 32, 31, 0, 0);
        for (int s = 0; s < 4; s++) run_slot(0, 32, 31, 0, 0);
        chk("basic_sop_count", sop_ants.size(), 5);
        for (int s = 0; s < 5 && s < sop_ants.size(); s++) chk("basic_ant", sop_ants[s], s % NUM_ANT);
        chk("basic_fram_once", fram_seen, 1);
        chk("basic_eops", eop_seen, 5);

        // 20M back-to-back slots
        clear_stats();
        run_slot(1, 16, 15, 0, 0);
        for (int s = 0; s < 3; s++) run_slot(0, 16, 15, 0, 0);
        chk("m20_vld_cycles", vld_seen, 32);
        chk("m20_fill_cnt", o_fill_cnt, 0);

        // Misaligned i_xant at phase 20 of slot 1
        step(0, 0, 1, 0, 1, 0);
        run_slot(1, 32, 31, 0, 0);
        run_slot(0, 32, 20, 0, 0);
        chk("mis_align_cnt", o_align_cnt, 1);
        chk("mis_align_err", o_align_err, 1);
        clear_stats();
        run_slot(0, 32, 31, 0, 0);
        chk("mis_next_ant", sop_ants.size() > 0 ? sop_ants[0] : -1, 2);
        chk("mis_next_eop", eop_seen, 1);

        // Nonzero fill, clear, saturation
        step(0, 0, 1, 0, 1, 0);
        run_slot(1, 32, 31, 32'hDEAD, 3);
        chk("fill_three", o_fill_cnt, 3);
        step(0, 0, 1, 32'h1234, 1, 0);
        chk("fill_clear", o_fill_cnt, 0);
        for (int s = 0; s < 19; s++) run_slot(0, 32, 31, 32'hFFFF_FFFF, 16);
        chk("fill_saturate", o_fill_cnt, 255);

        // Resync by i_fram at phase 11
        run_slot(1, 32, 31, 0, 0);
        clear_stats();
        for (int q = 0; q < 11; q++) step(0, 0, 1, (q < 8) ? 32'h300 + 32'(q) : 32'h400 + 32'(q - 8), 0, 0);
        chk("resync_no_eop", eop_seen, 0);
        clear_stats();
        run_slot(1, 32, 31, 0, 0);
        chk("resync_ant0", sop_ants.size() > 0 ? sop_ants[0] : -1, 0);
        chk("resync_fram", fram_seen, 1);
        chk("resync_eop", eop_seen, 1);

        // Reset at phase 10, then i_xant in IDLE
        run_slot(1, 32, 31, 0, 0);
        for (int q = 0; q < 10; q++) step(0, 0, 1, 32'h100 + 32'(q), 0, 0);
        step(0, 0, 1, 32'h202, 0, 1);
        chk("rst_vld", o_vld, 0);
        for (int q = 0; q < 20; q++) step(0, 1, 1, 32'hABC, 0, 0);
        chk("rst_idle_vld", o_vld, 0);
        chk("rst_idle_align", o_align_cnt, 0);
        chk("rst_idle_err", o_align_err, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic fr, xa, clr, rs;
            logic [31:0] d;
            fr  = ($urandom_range(0, 99) == 0);
            if (m_run && m_phase == m_len - 1) xa = ($urandom_range(0, 7) != 0);
            else xa = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 79) == 0);
            rs  = ($urandom_range(0, 699) == 0);
            if (m_run && m_phase >= 16) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
            else d = $urandom;
            step(fr, xa, 2'($urandom), d, clr, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
